cdd_link_responder: RTL
=======================

Name: cdd_link_responder

Overview:
- Drive-side end of the CD drive nibble link to the CD system register block.
- The CD system block drives CDD_DIN and HOCK and reads CDD_DOUT and CDCK. This block answers on the other side of those same wires.
- Once per period it raises CD_nIRQ, then exchanges a 10-nibble frame in both directions:
  - drive → host: status, 9 nibbles plus checksum.
  - host → drive: command, 9 nibbles plus checksum.
- It checks the received command checksum and presents the command to the drive model.

Parameters:
- IRQ_PERIOD, 160000: cycles between frame starts (about 75 Hz at 12 MHz).
- IRQ_PULSE, 16: CD_nIRQ low width in cycles.
- TIMEOUT, 65535: maximum cycles spent waiting on any single HOCK edge.

Ports:
- nRESET  in  1  async reset, active-low
- CLK_68KCLK  in  1  clock
- HOCK  in  1  host handshake, asynchronous to this block
- CDD_DIN  in  4  host command nibble
- CDCK  out  1  drive handshake
- CDD_DOUT  out  4  drive status nibble
- CD_nIRQ  out  1  frame-start request, active-low
- STATUS_IN  in  36  status nibbles 0..8; nibble i is bits [4i+3:4i]
- STATUS_LATCH  out  1  one-cycle pulse when STATUS_IN is captured
- CMD_OUT  out  40  last good command; nibble i is bits [4i+3:4i]
- CMD_VALID  out  1  one-cycle pulse, good command received
- CMD_ERR  out  1  one-cycle pulse, checksum mismatch
- TIMEOUT_ERR  out  1  one-cycle pulse, frame aborted
- BUSY  out  1  high in any state other than IDLE

Behaviour:
- Reset: reset nRESET, asynchronous, active-low; clock CLK_68KCLK. Reset values:
  - CDCK=1, CDD_DOUT=0, CD_nIRQ=1, CMD_OUT=0.
  - All pulses 0, BUSY=0, state IDLE, period counter 0, nibble index 0.
  - Reset during a frame aborts it immediately; no pulse is emitted for the aborted frame.
- HOCK synchronisation: HOCK passes through a 2-flop synchronizer; the FSM uses only the synced value HS.
- Period counter:
  - Free-running from 0 to IRQ_PERIOD-1, then wraps to 0.
  - The tick occurs when the counter equals IRQ_PERIOD-1.
  - A tick while not in IDLE is dropped; no queueing.
- Checksum: low 4 bits of the bitwise NOT of the 4-bit-wrapped sum of nibbles 0..8.
- FSM, one transition per cycle at most:
  - IDLE: on tick, latch STATUS_IN into the internal status register and set nibble 9 to the computed checksum. Pulse STATUS_LATCH, drive CD_nIRQ=0, go to IRQ.
  - IRQ: hold CD_nIRQ low for IRQ_PULSE cycles, then drive CD_nIRQ=1. Set index=0, drive CDD_DOUT=status[0] and CDCK=0 in the same cycle, go to WAIT_HLOW.
  - WAIT_HLOW: when HS==0, capture CDD_DIN into cmd_shadow[index], drive CDCK=1, go to WAIT_HHIGH.
  - WAIT_HHIGH: when HS==1:
    - if index==9, go to CHECK;
    - otherwise increment index, drive CDD_DOUT=status[index+1] and CDCK=0 in the same cycle, go to WAIT_HLOW.
  - CHECK, one cycle:
    - if shadow nibble 9 equals the checksum of shadow 0..8, set CMD_OUT=shadow and pulse CMD_VALID;
    - otherwise pulse CMD_ERR and leave CMD_OUT unchanged.
    - Go to IDLE with CDD_DOUT=0 and CDCK=1.
- CDD_DOUT stays stable whenever CDCK=0, so the host reads it before dropping HOCK.
- Timeout:
  - A wait counter clears on entry to WAIT_HLOW and WAIT_HHIGH.
  - Reaching TIMEOUT in either state pulses TIMEOUT_ERR and returns to IDLE with CDCK=1 and CDD_DOUT=0.
  - The command shadow is discarded and CMD_OUT is unchanged.
- Edge cases:
  - HOCK already low on entry to WAIT_HLOW is accepted immediately; the host owns the protocol.
  - Changes to STATUS_IN during a frame have no effect until the next tick.
- Latency: HOCK edge to CDCK response is 3 cycles (2 synchronizer cycles plus 1 registered FSM cycle).

Decomposition:
- Package cdd_pkg holds:
  - CDD_NIBBLES=10;
  - the state enum {IDLE, IRQ, WAIT_HLOW, WAIT_HHIGH, CHECK};
  - a function cdd_checksum(36-bit) returning a 4-bit value.
- The system-side block also uses the checksum function.
- One sub-module: cdd_sync, a 2-flop synchronizer with reset value 1.

Test Plan:
1. Normal frame:
   - Stimulus: STATUS_IN=0; host BFM sends command nibbles 1,0,0,0,0,0,0,0,0,E.
   - Required: CDD_DOUT sequence 0×9 then F; CMD_VALID pulses once; CMD_OUT=40'hE000000001; BUSY falls.
2. Bad checksum:
   - Stimulus: same frame but nibble 9=0.
   - Required: CMD_ERR pulses once, CMD_VALID stays 0, CMD_OUT keeps its previous value.
3. Timeout:
   - Stimulus: BFM stops after nibble 3 with HOCK held high.
   - Required: exactly TIMEOUT cycles later TIMEOUT_ERR pulses; state IDLE, CDCK=1, CDD_DOUT=0.
4. Status snapshot:
   - Stimulus: change STATUS_IN to 36'h123456789 after STATUS_LATCH.
   - Required: the current frame still sends the old values; the next frame sends 9,8,7,6,5,4,3,2,1 then checksum 2.
5. Dropped tick:
   - Stimulus: IRQ_PERIOD=200; slow BFM keeps the frame open for 300 cycles.
   - Required: no second CD_nIRQ during the frame; next IRQ occurs at the first tick after IDLE.
6. Reset mid-frame:
   - Stimulus: assert nRESET at nibble 5.
   - Required: all outputs at reset values immediately; no pulses; the next frame restarts at nibble 0.

Source files
------------

// File: rtl/cdd_pkg.sv
// Shared definitions for the CD drive nibble link.
// Holds the frame length, the responder state type and the frame checksum
// that is used by both ends of the link.
package cdd_pkg;

    localparam int unsigned CDD_NIBBLES = 10;

    typedef enum logic [2:0] {
        IDLE,
        IRQ,
        WAIT_HLOW,
        WAIT_HHIGH,
        CHECK
    } cdd_state_t;

    // Checksum of nibbles 0..8: bitwise NOT of their 4-bit wrapped sum.
    function automatic logic [3:0] cdd_checksum(input logic [35:0] nibbles);
        logic [3:0] sum;
        sum = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            sum = sum + nibbles[4*i +: 4];
        end
        return ~sum;
    endfunction

endpackage

// File: rtl/cdd_sync.sv
// Two-flop synchronizer for the host handshake line.
// Ports: nRESET (async, active-low), CLK_68KCLK, d (async input),
//        q (synchronised output, resets to 1 = handshake idle level).
module cdd_sync (
    input  logic nRESET,
    input  logic CLK_68KCLK,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge CLK_68KCLK or negedge nRESET) begin
        if (!nRESET) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cdd_link_responder.sv
// Drive-side responder of the CD drive nibble link.
// Every IRQ_PERIOD cycles it pulls CD_nIRQ low, then swaps a 10-nibble frame
// with the host: status out on CDD_DOUT/CDCK, command in on CDD_DIN/HOCK.
// Ports:
//   nRESET, CLK_68KCLK        async active-low reset, clock
//   HOCK, CDD_DIN             host handshake (async) and command nibble
//   CDCK, CDD_DOUT, CD_nIRQ   drive handshake, status nibble, frame request
//   STATUS_IN, STATUS_LATCH   status nibbles 0..8 and their capture pulse
//   CMD_OUT, CMD_VALID        last good command and its arrival pulse
//   CMD_ERR, TIMEOUT_ERR      checksum failure / aborted frame pulses
//   BUSY                      high outside IDLE
module cdd_link_responder
    import cdd_pkg::*;
#(
    parameter int unsigned IRQ_PERIOD = 160000,
    parameter int unsigned IRQ_PULSE  = 16,
    parameter int unsigned TIMEOUT    = 65535
) (
    input  logic        nRESET,
    input  logic        CLK_68KCLK,
    input  logic        HOCK,
    input  logic [3:0]  CDD_DIN,
    output logic        CDCK,
    output logic [3:0]  CDD_DOUT,
    output logic        CD_nIRQ,
    input  logic [35:0] STATUS_IN,
    output logic        STATUS_LATCH,
    output logic [39:0] CMD_OUT,
    output logic        CMD_VALID,
    output logic        CMD_ERR,
    output logic        TIMEOUT_ERR,
    output logic        BUSY
);

    localparam int unsigned PW = $clog2(IRQ_PERIOD + 1);
    localparam int unsigned QW = $clog2(IRQ_PULSE + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    cdd_state_t  state, state_d;
    logic [PW-1:0] period_cnt;
    logic        tick;
    logic        hs;
    logic [QW-1:0] pulse_cnt, pulse_cnt_d;
    logic [TW-1:0] wait_cnt, wait_cnt_d;
    logic [3:0]  idx, idx_d, idx_next;
    logic [39:0] status_q, status_d;
    logic [39:0] shadow, shadow_d;
    logic [39:0] cmd_out_q, cmd_out_d;
    logic        cdck_q, cdck_d;
    logic [3:0]  dout_q, dout_d;
    logic        nirq_q, nirq_d;
    logic        latch_q, latch_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        tout_q, tout_d;

    cdd_sync u_hock_sync (
        .nRESET     (nRESET),
        .CLK_68KCLK (CLK_68KCLK),
        .d          (HOCK),
        .q          (hs)
    );

    // Free-running frame timer; ticks arriving outside IDLE are simply lost.
    assign tick = (period_cnt == PW'(IRQ_PERIOD - 1));

    always_ff @(posedge CLK_68KCLK or negedge nRESET) begin
        if (!nRESET) begin
            period_cnt <= '0;
        end else if (tick) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + PW'(1);
        end
    end

    always_ff @(posedge CLK_68KCLK or negedge nRESET) begin
        if (!nRESET) begin
            state     <= IDLE;
            pulse_cnt <= '0;
            wait_cnt  <= '0;
            idx       <= '0;
            status_q  <= '0;
            shadow    <= '0;
            cmd_out_q <= '0;
            cdck_q    <= 1'b1;
            dout_q    <= '0;
            nirq_q    <= 1'b1;
            latch_q   <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            tout_q    <= 1'b0;
        end else begin
            state     <= state_d;
            pulse_cnt <= pulse_cnt_d;
            wait_cnt  <= wait_cnt_d;
            idx       <= idx_d;
            status_q  <= status_d;
            shadow    <= shadow_d;
            cmd_out_q <= cmd_out_d;
            cdck_q    <= cdck_d;
            dout_q    <= dout_d;
            nirq_q    <= nirq_d;
            latch_q   <= latch_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            tout_q    <= tout_d;
        end
    end

    always_comb begin
        state_d     = state;
        pulse_cnt_d = pulse_cnt;
        wait_cnt_d  = wait_cnt;
        idx_d       = idx;
        idx_next    = idx + 4'd1;
        status_d    = status_q;
        shadow_d    = shadow;
        cmd_out_d   = cmd_out_q;
        cdck_d      = cdck_q;
        dout_d      = dout_q;
        nirq_d      = nirq_q;
        latch_d     = 1'b0;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        tout_d      = 1'b0;

        case (state)
            IDLE: begin
                if (tick) begin
                    status_d    = {cdd_checksum(STATUS_IN), STATUS_IN};
                    latch_d     = 1'b1;
                    nirq_d      = 1'b0;
                    pulse_cnt_d = '0;
                    state_d     = IRQ;
                end
            end
            IRQ: begin
                if (pulse_cnt == QW'(IRQ_PULSE - 1)) begin
                    nirq_d     = 1'b1;
                    idx_d      = '0;
                    dout_d     = status_q[3:0];
                    cdck_d     = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = WAIT_HLOW;
                end else begin
                    pulse_cnt_d = pulse_cnt + QW'(1);
                end
            end
            WAIT_HLOW: begin
                if (!hs) begin
                    shadow_d[{idx, 2'b00} +: 4] = CDD_DIN;
                    cdck_d     = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = WAIT_HHIGH;
                end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                    tout_d   = 1'b1;
                    cdck_d   = 1'b1;
                    dout_d   = '0;
                    shadow_d = '0;
                    state_d  = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt + TW'(1);
                end
            end
            WAIT_HHIGH: begin
                if (hs) begin
                    if (idx == 4'(CDD_NIBBLES - 1)) begin
                        state_d = CHECK;
                    end else begin
                        // Next nibble goes out together with CDCK low so it is
                        // already stable when the host sees the falling edge.
                        idx_d      = idx_next;
                        dout_d     = status_q[{idx_next, 2'b00} +: 4];
                        cdck_d     = 1'b0;
                        wait_cnt_d = '0;
                        state_d    = WAIT_HLOW;
                    end
                end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                    tout_d   = 1'b1;
                    cdck_d   = 1'b1;
                    dout_d   = '0;
                    shadow_d = '0;
                    state_d  = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt + TW'(1);
                end
            end
            CHECK: begin
                if (shadow[39:36] == cdd_checksum(shadow[35:0])) begin
                    cmd_out_d = shadow;
                    valid_d   = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                dout_d  = '0;
                cdck_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign CDCK         = cdck_q;
    assign CDD_DOUT     = dout_q;
    assign CD_nIRQ      = nirq_q;
    assign STATUS_LATCH = latch_q;
    assign CMD_OUT      = cmd_out_q;
    assign CMD_VALID    = valid_q;
    assign CMD_ERR      = err_q;
    assign TIMEOUT_ERR  = tout_q;
    assign BUSY         = (state != IDLE);

endmodule
